// File: rtl/bpred_pkg.sv
// Shared constants, entry layout and FSM state for the branch resolve queue.
package bpred_pkg;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned HIST      = 8;
    localparam int unsigned MAXPUSH   = 4;
    localparam int unsigned ENTRY_W   = 33;
    localparam int unsigned TAKEN_BIT = 0;
    localparam int unsigned ADDR_LSB  = 1;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned PW        = AW + 1;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

endpackage

// File: rtl/bpred_hist_ram.sv
// DEPTH x 33 entry store: multi-entry write port, taken-bit patch port,
// combinational head read and a registered HIST-wide history tap.
module bpred_hist_ram
    import bpred_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [AW-1:0]               wr_idx_i,
    input  logic [2:0]                  wr_num_i,
    input  logic [MAXPUSH*ENTRY_W-1:0]  wr_data_i,
    input  logic                        patch_en_i,
    input  logic [AW-1:0]               patch_idx_i,
    input  logic                        patch_bit_i,
    input  logic [AW-1:0]               rd_idx_i,
    output entry_t                      head_o,
    input  logic [AW-1:0]               tap_idx_i,
    output logic [HIST*ENTRY_W-1:0]     hist_o
);

    entry_t                  mem_q [DEPTH];
    entry_t                  mem_d [DEPTH];
    logic [HIST*ENTRY_W-1:0] hist_q;
    logic [HIST*ENTRY_W-1:0] hist_d;

    // History taps read the post-update array so the window is current one cycle after acceptance.
    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            for (int unsigned k = 0; k < MAXPUSH; k++) begin
                if (k < 32'(wr_num_i)) begin
                    mem_d[wr_idx_i + AW'(k)] = wr_data_i[k*ENTRY_W +: ENTRY_W];
                end
            end
        end
        if (patch_en_i) begin
            mem_d[patch_idx_i][TAKEN_BIT] = patch_bit_i;
        end
        hist_d = '0;
        for (int unsigned j = 0; j < HIST; j++) begin
            hist_d[j*ENTRY_W +: ENTRY_W] = mem_d[tap_idx_i - AW'(j + 1)];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            mem_q  <= mem_d;
            hist_q <= hist_d;
        end
    end

    assign head_o = mem_q[rd_idx_i];
    assign hist_o = hist_q;

endmodule

// File: rtl/bpred_resolve_queue.sv
// Program-ordered queue of predicted conditional branches: accepts predictions,
// retires resolutions, rewinds on mispredict and feeds history back to the predictor.
module bpred_resolve_queue
    import bpred_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push_valid,
    input  logic [2:0]    i_push_num_3,
    input  logic [131:0]  i_push_entries_132,
    output logic          o_push_ready,
    input  logic          i_resolve_valid,
    input  logic          i_resolve_taken,
    input  logic [31:0]   i_resolve_nextpc_32,
    output logic          o_resolve_ready,
    output logic [263:0]  o_globalHistoryRegister_264,
    output logic [4:0]    o_pendingB_5,
    output logic [31:0]   o_correctPC_32,
    output logic [31:0]   o_errAddr_32,
    output logic          o_errTaken_1
);

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          push_ready_q, push_ready_d;
    logic          res_ready_q, res_ready_d;
    logic [31:0]   cpc_q, cpc_d;
    logic [31:0]   eaddr_q, eaddr_d;
    logic          etaken_q, etaken_d;

    logic [2:0]    push_num;
    logic          push_fire;
    logic          res_fire;
    logic          mispredict;
    logic          push_en;
    entry_t        head;

    always_comb begin
        push_num   = (i_push_num_3 > 3'(MAXPUSH)) ? 3'(MAXPUSH) : i_push_num_3;
        push_fire  = (state_q == RUN) && i_push_valid && push_ready_q;
        res_fire   = (state_q == RUN) && i_resolve_valid && res_ready_q;
        mispredict = res_fire && (i_resolve_taken != head[TAKEN_BIT]);
        push_en    = push_fire && !mispredict;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = RUN;
        cpc_d    = '0;
        eaddr_d  = '0;
        etaken_d = 1'b0;

        // A mispredict truncates the queue just past the head, discarding same-cycle pushes.
        if (mispredict) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            wr_ptr_d = rd_ptr_q + PW'(1);
            state_d  = RECOVER;
            cpc_d    = i_resolve_nextpc_32;
            eaddr_d  = head[ADDR_LSB +: 32];
            etaken_d = i_resolve_taken;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PW'(push_num);
            end
            if (res_fire) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end

        pend_d       = wr_ptr_d - rd_ptr_d;
        push_ready_d = (state_d == RUN) && (pend_d <= PW'(DEPTH - MAXPUSH));
        res_ready_d  = (state_d == RUN) && (pend_d != '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_q       <= '0;
            push_ready_q <= 1'b1;
            res_ready_q  <= 1'b0;
            cpc_q        <= '0;
            eaddr_q      <= '0;
            etaken_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pend_q       <= pend_d;
            push_ready_q <= push_ready_d;
            res_ready_q  <= res_ready_d;
            cpc_q        <= cpc_d;
            eaddr_q      <= eaddr_d;
            etaken_q     <= etaken_d;
        end
    end

    bpred_hist_ram u_ram (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .wr_en_i     (push_en),
        .wr_idx_i    (wr_ptr_q[AW-1:0]),
        .wr_num_i    (push_num),
        .wr_data_i   (i_push_entries_132),
        .patch_en_i  (mispredict),
        .patch_idx_i (rd_ptr_q[AW-1:0]),
        .patch_bit_i (i_resolve_taken),
        .rd_idx_i    (rd_ptr_q[AW-1:0]),
        .head_o      (head),
        .tap_idx_i   (wr_ptr_d[AW-1:0]),
        .hist_o      (o_globalHistoryRegister_264)
    );

    assign o_push_ready    = push_ready_q;
    assign o_resolve_ready = res_ready_q;
    assign o_pendingB_5    = pend_q;
    assign o_correctPC_32  = cpc_q;
    assign o_errAddr_32    = eaddr_q;
    assign o_errTaken_1    = etaken_q;

endmodule

// File: tb/tb_bpred_resolve_queue.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_bpred_resolve_queue;

    logic          clk;
    logic          i_rst_n;
    logic          i_push_valid;
    logic [2:0]    i_push_num_3;
    logic [131:0]  i_push_entries_132;
    logic          o_push_ready;
    logic          i_resolve_valid;
    logic          i_resolve_taken;
    logic [31:0]   i_resolve_nextpc_32;
    logic          o_resolve_ready;
    logic [263:0]  o_hist;
    logic [4:0]    o_pendingB_5;
    logic [31:0]   o_correctPC_32;
    logic [31:0]   o_errAddr_32;
    logic          o_errTaken_1;

    bpred_resolve_queue dut (
        .i_clk                       (clk),
        .i_rst_n                     (i_rst_n),
        .i_push_valid                (i_push_valid),
        .i_push_num_3                (i_push_num_3),
        .i_push_entries_132          (i_push_entries_132),
        .o_push_ready                (o_push_ready),
        .i_resolve_valid             (i_resolve_valid),
        .i_resolve_taken             (i_resolve_taken),
        .i_resolve_nextpc_32         (i_resolve_nextpc_32),
        .o_resolve_ready             (o_resolve_ready),
        .o_globalHistoryRegister_264 (o_hist),
        .o_pendingB_5                (o_pendingB_5),
        .o_correctPC_32              (o_correctPC_32),
        .o_errAddr_32                (o_errAddr_32),
        .o_errTaken_1                (o_errTaken_1)
    );

    localparam int K_PEND = 0, K_PRDY = 1, K_RRDY = 2, K_CPC = 3, K_EADDR = 4, K_ETAKEN = 5, K_SLOT = 10;

    typedef struct {
        int          due;
        int          kind;
        logic [32:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_m;
    logic [32:0] act_m;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] ents [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] actual(int kind);
        case (kind)
            K_PEND:   return 33'(o_pendingB_5);
            K_PRDY:   return 33'(o_push_ready);
            K_RRDY:   return 33'(o_resolve_ready);
            K_CPC:    return 33'(o_correctPC_32);
            K_EADDR:  return 33'(o_errAddr_32);
            K_ETAKEN: return 33'(o_errTaken_1);
            default:  return o_hist[(kind-K_SLOT)*33 +: 33];
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e_m   = sb.pop_front();
            act_m = actual(e_m.kind);
            checks++;
            if (e_m.due != cyc || act_m !== e_m.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)", e_m.name, act_m, e_m.val, cyc, e_m.due);
            end
        end
    end

    function automatic logic [32:0] ent(logic [31:0] a, logic t);
        return {a, t};
    endfunction

    task automatic exp_push(string name, int kind, logic [32:0] val);
        exp_t e;
        e.due  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic chk_state(string tag, int pend, bit prdy, bit rrdy);
        exp_push({tag, "_pend"}, K_PEND, 33'(pend));
        exp_push({tag, "_prdy"}, K_PRDY, 33'(prdy));
        exp_push({tag, "_rrdy"}, K_RRDY, 33'(rrdy));
    endtask

    task automatic chk_err(string tag, logic [31:0] cpc, logic [31:0] eaddr, bit etaken);
        exp_push({tag, "_cpc"}, K_CPC, 33'(cpc));
        exp_push({tag, "_eaddr"}, K_EADDR, 33'(eaddr));
        exp_push({tag, "_etaken"}, K_ETAKEN, 33'(etaken));
    endtask

    task automatic idle();
        i_push_valid        = 1'b0;
        i_push_num_3        = '0;
        i_push_entries_132  = '0;
        i_resolve_valid     = 1'b0;
        i_resolve_taken     = 1'b0;
        i_resolve_nextpc_32 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        tick();
        idle();
    endtask

    task automatic drive_push(int n);
        i_push_valid = 1'b1;
        i_push_num_3 = 3'(n);
        for (int k = 0; k < 4; k++) i_push_entries_132[k*33 +: 33] = ents[k];
    endtask

    task automatic drive_resolve(bit t, logic [31:0] pc);
        i_resolve_valid     = 1'b1;
        i_resolve_taken     = t;
        i_resolve_nextpc_32 = pc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        i_rst_n = 1'b0;
        tick();
        tick();
        chk_state("reset", 0, 1, 0);
        chk_err("reset", 0, 0, 0);
        exp_push("reset_slot0", K_SLOT + 0, 33'h0);
        tick();
        i_rst_n = 1'b1;

        ents = '{ent(32'h100, 1), ent(32'h104, 0), ent(32'h108, 1), 33'h0};
        drive_push(3);
        cycle();
        chk_state("push3", 3, 1, 1);
        exp_push("push3_slot0", K_SLOT + 0, 33'h211);
        exp_push("push3_slot1", K_SLOT + 1, 33'h208);
        exp_push("push3_slot2", K_SLOT + 2, 33'h201);

        drive_resolve(1, 32'h0);
        cycle();
        chk_state("res_ok", 2, 1, 1);
        chk_err("res_ok", 0, 0, 0);

        ents = '{ent(32'h300, 1), ent(32'h304, 1), 33'h0, 33'h0};
        drive_push(2);
        drive_resolve(1, 32'h200);
        cycle();
        chk_state("mispredict", 0, 0, 0);
        chk_err("mispredict", 32'h200, 32'h104, 1);
        exp_push("mispredict_slot0", K_SLOT + 0, 33'h209);
        exp_push("mispredict_slot1", K_SLOT + 1, 33'h201);
        exp_push("mispredict_slot2", K_SLOT + 2, 33'h0);

        ents = '{ent(32'h400, 1), 33'h0, 33'h0, 33'h0};
        drive_push(1);
        drive_resolve(0, 32'h0);
        cycle();
        chk_state("recover_exit", 0, 1, 0);
        chk_err("recover_exit", 0, 0, 0);
        exp_push("recover_exit_slot0", K_SLOT + 0, 33'h209);

        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) ents[k] = ent(32'h2000 + 32'(16*p + 4*k), 1'b1);
            drive_push(4);
            cycle();
            chk_state($sformatf("fill%0d", p), 4*(p+1), p < 3, 1);
        end
        exp_push("fill_slot0", K_SLOT + 0, ent(32'h203C, 1));

        for (int r = 0; r < 16; r++) begin
            drive_resolve(1, 32'h0);
            cycle();
            chk_state($sformatf("drain%0d", r), 15 - r, (15 - r) <= 12, (15 - r) != 0);
        end

        for (int k = 0; k < 20; k++) begin
            ents[0] = ent(32'h1000 + 32'(4*k), 1'(k % 2));
            drive_push(1);
            cycle();
            drive_resolve(1'(k % 2), 32'h0);
            cycle();
        end
        chk_state("wrap", 0, 1, 0);
        for (int j = 0; j < 8; j++)
            exp_push($sformatf("wrap_slot%0d", j), K_SLOT + j, ent(32'h1000 + 32'(4*(19-j)), 1'((19-j) % 2)));

        ents[0] = ent(32'h5000, 0);
        drive_push(1);
        cycle();
        chk_state("pre_pair", 1, 1, 1);
        ents = '{ent(32'h5004, 1), ent(32'h5008, 0), 33'h0, 33'h0};
        drive_push(2);
        drive_resolve(0, 32'h0);
        cycle();
        chk_state("push_res", 2, 1, 1);
        exp_push("push_res_slot0", K_SLOT + 0, ent(32'h5008, 0));
        exp_push("push_res_slot1", K_SLOT + 1, ent(32'h5004, 1));
        exp_push("push_res_slot2", K_SLOT + 2, ent(32'h5000, 0));

        ents = '{ent(32'h7000, 1), ent(32'h7004, 1), 33'h0, 33'h0};
        drive_push(0);
        cycle();
        chk_state("push0", 2, 1, 1);
        exp_push("push0_slot0", K_SLOT + 0, ent(32'h5008, 0));

        drive_resolve(1, 32'h0);
        cycle();
        drive_resolve(0, 32'h0);
        cycle();
        chk_state("empty", 0, 1, 0);
        drive_resolve(1, 32'hDEAD);
        cycle();
        chk_state("res_empty", 0, 1, 0);
        chk_err("res_empty", 0, 0, 0);
        exp_push("res_empty_slot0", K_SLOT + 0, ent(32'h5008, 0));

        ents[0] = ent(32'h6000, 0);
        drive_push(1);
        cycle();
        drive_resolve(1, 32'h6004);
        cycle();
        chk_state("mp2", 0, 0, 0);
        chk_err("mp2", 32'h6004, 32'h6000, 1);
        exp_push("mp2_slot0", K_SLOT + 0, ent(32'h6000, 1));

        // Short reset pulse between clock edges, inside the RECOVER cycle.
        @(negedge clk);
        #1;
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
        tick();
        chk_state("rst_recover", 0, 1, 0);
        chk_err("rst_recover", 0, 0, 0);
        exp_push("rst_recover_slot0", K_SLOT + 0, 33'h0);

        ents = '{ent(32'h8000, 1), ent(32'h8004, 0), ent(32'h8008, 1), ent(32'h800C, 0)};
        drive_push(7);
        cycle();
        chk_state("clamp", 4, 1, 1);
        exp_push("clamp_slot0", K_SLOT + 0, ent(32'h800C, 0));
        exp_push("clamp_slot3", K_SLOT + 3, ent(32'h8000, 1));

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
